// File: rtl/seq_scan_ctrl.sv
// seq_scan_ctrl
// Sequencing controller for a serial Mealy "0110" (overlapping) detector.
// A parallel word is captured on start. The detector is cleared for one cycle.
// The word is then shifted into the detector MSB-first, one bit per clock.
// The controller records which bit positions completed a detection (hit_map)
// and how many detections occurred (hit_count, saturating).
//
// Handshake: start acts as a request that is accepted only while the FSM is
// in IDLE. An accepted start captures data_in on that edge. start is ignored
// in CLEAR, SHIFT and DONE, and data_in is not re-captured in those states.
// done is a one-cycle pulse that marks hit_count and hit_map as final. They
// hold their values until the next accepted start or reset.
//
// Ports:
//   clk        system clock, rising edge
//   reset      synchronous active-low reset
//   start      scan request (sampled in IDLE only)
//   data_in    word to scan
//   busy       high during CLEAR and SHIFT
//   done       one-cycle result-valid pulse
//   det_x      serial bit to detector (combinational: MSB gated by SHIFT)
//   det_rst    active-high detector reset (high during CLEAR)
//   det_z      detector Mealy output for the current det_x
//   hit_count  number of detections in the last scan (saturating)
//   hit_map    bit k set iff a detection completed on data_in[k]
//   fsm_state  current FSM state for observation (0 IDLE, 1 CLEAR, 2 SHIFT, 3 DONE)
module seq_scan_ctrl #(
    parameter int WIDTH = 16,
    parameter int CNT_W = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] data_in,
    output logic             busy,
    output logic             done,
    output logic             det_x,
    output logic             det_rst,
    input  logic             det_z,
    output logic [CNT_W-1:0] hit_count,
    output logic [WIDTH-1:0] hit_map,
    output logic [1:0]       fsm_state
);

    localparam int IDX_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CLEAR = 2'd1,
        SHIFT = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t           state;
    state_t           next_state;
    logic [WIDTH-1:0] shreg;
    logic [IDX_W-1:0] index;

    // Next values of the registered outputs, decoded from next_state.
    logic busy_d;
    logic done_d;
    logic det_rst_d;

    // State register together with the registered control outputs.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state   <= IDLE;
            busy    <= 1'b0;
            done    <= 1'b0;
            det_rst <= 1'b0;
        end else begin
            state   <= next_state;
            busy    <= busy_d;
            done    <= done_d;
            det_rst <= det_rst_d;
        end
    end

    // Next-state logic.
    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (start) next_state = CLEAR;
            CLEAR:   next_state = SHIFT;
            SHIFT:   if (index == LAST_IDX) next_state = DONE;
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Output decode. The outputs are computed from next_state so that the
    // registered copies line up with the state they describe.
    always_comb begin
        busy_d    = 1'b0;
        done_d    = 1'b0;
        det_rst_d = 1'b0;
        case (next_state)
            CLEAR: begin
                busy_d    = 1'b1;
                det_rst_d = 1'b1;
            end
            SHIFT:   busy_d = 1'b1;
            DONE:    done_d = 1'b1;
            default: ;
        endcase
    end

    // det_x must follow the shift register within the same cycle, because the
    // Mealy det_z depends on it combinationally. It is therefore not registered.
    assign det_x     = (state == SHIFT) & shreg[WIDTH-1];
    assign fsm_state = state;

    // Datapath: capture, shift and result accumulation.
    always_ff @(posedge clk) begin
        if (!reset) begin
            shreg     <= '0;
            index     <= '0;
            hit_count <= '0;
            hit_map   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        shreg     <= data_in;
                        index     <= '0;
                        hit_count <= '0;
                        hit_map   <= '0;
                    end
                end
                SHIFT: begin
                    shreg   <= {shreg[WIDTH-2:0], 1'b0};
                    // The first bit shifted in ends up at position WIDTH-1.
                    // That bit was data_in[WIDTH-1], so hit_map lines up with data_in.
                    hit_map <= {hit_map[WIDTH-2:0], det_z};
                    index   <= index + IDX_W'(1);
                    if (det_z && (hit_count != CNT_MAX)) begin
                        hit_count <= hit_count + CNT_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_seq_scan_ctrl.sv
// Testbench for seq_scan_ctrl.
// Two instances share the same stimulus: CNT_W=5 (a) and CNT_W=2 (b, saturating).
// Each instance drives a behavioural 0110 Mealy detector model.
// Expected results are pushed to per-instance queues when a scan is issued.
// A monitor pops and compares them on every done pulse.
module tb_seq_scan_ctrl;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic        start;
    logic [15:0] data_in;

    // ---------------- DUT a (CNT_W=5) ----------------
    logic        busy_a, done_a, det_x_a, det_rst_a, det_z_a;
    logic [4:0]  hit_count_a;
    logic [15:0] hit_map_a;
    logic [1:0]  fsm_state_a;

    seq_scan_ctrl #(.WIDTH(16), .CNT_W(5)) dut_a (
        .clk(clk), .reset(reset), .start(start), .data_in(data_in),
        .busy(busy_a), .done(done_a), .det_x(det_x_a), .det_rst(det_rst_a),
        .det_z(det_z_a), .hit_count(hit_count_a), .hit_map(hit_map_a),
        .fsm_state(fsm_state_a)
    );

    // ---------------- DUT b (CNT_W=2) ----------------
    logic        busy_b, done_b, det_x_b, det_rst_b, det_z_b;
    logic [1:0]  hit_count_b;
    logic [15:0] hit_map_b;
    logic [1:0]  fsm_state_b;

    seq_scan_ctrl #(.WIDTH(16), .CNT_W(2)) dut_b (
        .clk(clk), .reset(reset), .start(start), .data_in(data_in),
        .busy(busy_b), .done(done_b), .det_x(det_x_b), .det_rst(det_rst_b),
        .det_z(det_z_b), .hit_count(hit_count_b), .hit_map(hit_map_b),
        .fsm_state(fsm_state_b)
    );

    // ---------------- detector models (0110 overlapping, Mealy) ----------------
    // Model states: 0 = start, 1 = seen "0", 2 = seen "01", 3 = seen "011".
    logic [1:0] ds_a = 2'd0;
    logic [1:0] ds_b = 2'd0;

    function automatic logic [1:0] next_ds(input logic [1:0] s, input logic x);
        case (s)
            2'd0:    next_ds = x ? 2'd0 : 2'd1;
            2'd1:    next_ds = x ? 2'd2 : 2'd1;
            2'd2:    next_ds = x ? 2'd3 : 2'd1;
            default: next_ds = x ? 2'd0 : 2'd1;
        endcase
    endfunction

    assign det_z_a = (ds_a == 2'd3) && !det_x_a;
    assign det_z_b = (ds_b == 2'd3) && !det_x_b;

    always @(posedge clk) begin
        if (!reset || det_rst_a) ds_a <= 2'd0;
        else                     ds_a <= next_ds(ds_a, det_x_a);
        if (!reset || det_rst_b) ds_b <= 2'd0;
        else                     ds_b <= next_ds(ds_b, det_x_b);
    end

    // ---------------- check bookkeeping ----------------
    int passed = 0;
    int total  = 0;

    task automatic chk(input string name, input int unsigned act, input int unsigned exp);
        total++;
        if (act == exp) passed++;
        else $display("FAIL %s actual=0x%0h expected=0x%0h at %0t", name, act, exp, $time);
    endtask

    // ---------------- scoreboard ----------------
    logic [20:0] exp_q_a[$];
    logic [20:0] exp_q_b[$];
    logic [20:0] e_a, e_b;

    task automatic push_exp(input logic [4:0] cnt, input logic [15:0] map);
        exp_q_a.push_back({cnt, map});
        exp_q_b.push_back({(cnt > 5'd3) ? 5'd3 : cnt, map});
    endtask

    always @(negedge clk) begin
        if (reset === 1'b1) begin
            if (done_a === 1'b1) begin
                if (exp_q_a.size() == 0) chk("unexpected_done_a", 1, 0);
                else begin
                    e_a = exp_q_a.pop_front();
                    chk("hit_count_a", hit_count_a, e_a[20:16]);
                    chk("hit_map_a", hit_map_a, e_a[15:0]);
                end
            end
            if (done_b === 1'b1) begin
                if (exp_q_b.size() == 0) chk("unexpected_done_b", 1, 0);
                else begin
                    e_b = exp_q_b.pop_front();
                    chk("hit_count_b", {3'b000, hit_count_b}, e_b[20:16]);
                    chk("hit_map_b", hit_map_b, e_b[15:0]);
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic check_idle_zero(input string tag);
        chk({tag, "_busy"}, busy_a, 0);
        chk({tag, "_done"}, done_a, 0);
        chk({tag, "_det_x"}, det_x_a, 0);
        chk({tag, "_det_rst"}, det_rst_a, 0);
        chk({tag, "_hit_count"}, hit_count_a, 0);
        chk({tag, "_hit_map"}, hit_map_a, 0);
        chk({tag, "_state"}, fsm_state_a, 0);
        chk({tag, "_hit_count_b"}, hit_count_b, 0);
    endtask

    // Issue one scan and follow its timing. With inject set, start is held
    // high with data 0xFFFF from the 5th cycle after acceptance through the
    // DONE cycle.
    task automatic run_scan(input logic [15:0] d, input bit inject);
        int cyc;
        int busy_n;
        start   = 1'b1;
        data_in = d;
        @(negedge clk);
        start = 1'b0;
        chk("clear_busy", busy_a, 1);
        chk("clear_det_rst", det_rst_a, 1);
        chk("clear_det_x", det_x_a, 0);
        cyc    = 1;
        busy_n = 0;
        while (!done_a && cyc < 40) begin
            if (busy_a) busy_n++;
            if (cyc == 2) begin
                chk("shift_det_rst", det_rst_a, 0);
                chk("shift_first_bit", det_x_a, d[15]);
                chk("det_model_cleared", ds_a, 0);
            end
            if (inject && cyc >= 5) begin
                start   = 1'b1;
                data_in = 16'hFFFF;
            end
            @(negedge clk);
            cyc++;
        end
        chk("done_latency", cyc, 18);
        chk("busy_cycles", busy_n, 17);
        chk("done_busy", busy_a, 0);
        chk("done_det_x", det_x_a, 0);
        @(negedge clk);
        chk("post_done_pulse_low", done_a, 0);
        chk("post_done_idle", busy_a, 0);
        if (inject) begin
            start = 1'b0;
            @(negedge clk);
            chk("inject_not_accepted", busy_a, 0);
        end
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int dn;
        reset   = 1'b0;
        start   = 1'b1;
        data_in = 16'hFFFF;
        repeat (3) @(negedge clk);
        check_idle_zero("reset");
        start = 1'b0;
        reset = 1'b1;
        @(negedge clk);

        push_exp(5'd4, 16'h1111);
        run_scan(16'h6666, 1'b0);

        push_exp(5'd4, 16'h0924);
        run_scan(16'h36D8, 1'b0);

        push_exp(5'd0, 16'h0000);
        run_scan(16'h0003, 1'b0);
        push_exp(5'd0, 16'h0000);
        run_scan(16'h0000, 1'b0);

        push_exp(5'd4, 16'h1111);
        run_scan(16'h6666, 1'b1);
        repeat (3) @(negedge clk);
        chk("hold_hit_count", hit_count_a, 4);
        chk("hold_hit_map", hit_map_a, 16'h1111);

        // Abort: pull reset low during the 5th SHIFT cycle.
        start   = 1'b1;
        data_in = 16'h36D8;
        @(negedge clk);
        start = 1'b0;
        repeat (5) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        check_idle_zero("abort");
        dn = 0;
        repeat (25) begin
            @(negedge clk);
            if (done_a || done_b) dn++;
        end
        chk("abort_no_done", dn, 0);

        push_exp(5'd4, 16'h1111);
        run_scan(16'h6666, 1'b0);

        repeat (2) @(negedge clk);
        chk("queue_a_drained", exp_q_a.size(), 0);
        chk("queue_b_drained", exp_q_b.size(), 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    // ---------------- watchdog ----------------
    initial begin
        #50000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
